// File: rtl/ddr4_wr_pkg.sv
`default_nettype none
// ============================================================================
// ddr4_wr_pkg -- shared types and AXI constants for the X_k DDR4 writer
// Rev 1.0
// ============================================================================
package ddr4_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wr_state_t;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // 512-bit beats needed to carry dim 64-bit elements
    function automatic int beats_for(input int dim);
        return (dim * 8 + 63) / 64;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr4_writer_xk_vec_fifo.sv
`default_nettype none
// ============================================================================
// vec_fifo -- whole-vector synchronous FIFO with explicit occupancy count
// Rev 1.0
// ============================================================================
module vec_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 768
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/ddr4_writer_xk.sv
`default_nettype none
// ============================================================================
// ddr4_writer_xk -- drains X_k state vectors into DDR4 as 512-bit AXI4 bursts
// Rev 1.0
// ============================================================================
module ddr4_writer_xk
    import ddr4_wr_pkg::*;
#(
    parameter int          STATE_DIM      = 12,
    parameter int          MAX_ITERATIONS = 100,
    parameter logic [31:0] ADDR_XK_BASE   = 32'h0080_0000,
    parameter int          WB_DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_write,
    input  logic [STATE_DIM*64-1:0] X_k_in,
    input  logic                    X_k_valid_in,
    output logic                    X_k_ready,
    output logic [31:0]             axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [511:0]            axi_wdata,
    output logic [63:0]             axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic                    all_X_k_written,
    output logic                    write_error,
    output logic                    overflow
);

    localparam int c_BEATS  = beats_for(STATE_DIM);
    localparam int c_VEC_W  = STATE_DIM * 64;
    localparam int c_PAD_W  = c_BEATS * 512;
    localparam int c_BIDX_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_CNT_W  = $clog2(MAX_ITERATIONS + 1);
    localparam logic [31:0]         c_STRIDE    = 32'(c_BEATS * 64);
    localparam logic [c_BIDX_W-1:0] c_LAST_BEAT = c_BIDX_W'(c_BEATS - 1);
    localparam logic [c_CNT_W-1:0]  c_MAX_CNT   = c_CNT_W'(MAX_ITERATIONS);
    localparam logic [c_CNT_W-1:0]  c_LAST_RESP = c_CNT_W'(MAX_ITERATIONS - 1);
    // one strobe bit per byte of the padded vector, low STATE_DIM*8 set
    localparam logic [c_BEATS*64-1:0] c_STRB_ALL =
        {(c_BEATS*64){1'b1}} >> (c_BEATS*64 - STATE_DIM*8);

    wr_state_t            r_state, w_state_nxt;
    logic [31:0]          r_awaddr, w_awaddr_nxt;
    logic                 r_awvalid, w_awvalid_nxt;
    logic [511:0]         r_wdata, w_wdata_nxt;
    logic [63:0]          r_wstrb, w_wstrb_nxt;
    logic                 r_wlast, w_wlast_nxt;
    logic                 r_wvalid, w_wvalid_nxt;
    logic                 r_bready, w_bready_nxt;
    logic [c_BIDX_W-1:0]  r_beat, w_beat_nxt, w_beat_inc;

    logic                 r_running;
    logic                 r_all_done;
    logic                 r_write_error;
    logic                 r_overflow;
    logic [c_CNT_W-1:0]   r_push_cnt;
    logic [c_CNT_W-1:0]   r_resp_cnt;
    logic [31:0]          r_wr_idx;

    logic                 w_start;
    logic                 w_done_acc;
    logic                 w_push;
    logic                 w_ovf_set;
    logic                 w_pop;
    logic                 w_resp_evt;
    logic                 w_err_set;
    logic                 w_batch_done;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_VEC_W-1:0]   w_head;
    logic [c_PAD_W-1:0]   w_head_pad;
    logic [511:0]         w_beats [c_BEATS];
    logic [63:0]          w_strbs [c_BEATS];

    assign w_start    = start_write & (~r_running | r_all_done);
    assign w_done_acc = (r_push_cnt == c_MAX_CNT);
    assign X_k_ready  = r_running & ~w_done_acc & ~w_fifo_full;
    assign w_push     = X_k_valid_in & X_k_ready;
    assign w_ovf_set  = X_k_valid_in & r_running & w_fifo_full & ~w_done_acc;

    vec_fifo #(
        .DEPTH (WB_DEPTH),
        .WIDTH (c_VEC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start),
        .push  (w_push),
        .pop   (w_pop),
        .din   (X_k_in),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .head  (w_head)
    );

    always_comb begin
        w_head_pad                = '0;
        w_head_pad[c_VEC_W-1:0]   = w_head;
    end

    for (genvar gi = 0; gi < c_BEATS; gi++) begin : g_beat
        assign w_beats[gi] = w_head_pad[gi*512 +: 512];
        assign w_strbs[gi] = c_STRB_ALL[gi*64 +: 64];
    end

    assign w_beat_inc = r_beat + c_BIDX_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_awaddr_nxt  = r_awaddr;
        w_awvalid_nxt = r_awvalid;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_wlast_nxt   = r_wlast;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_beat_nxt    = r_beat;
        w_pop         = 1'b0;
        w_resp_evt    = 1'b0;
        w_err_set     = 1'b0;
        w_batch_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt   = AW;
                    w_awaddr_nxt  = ADDR_XK_BASE + r_wr_idx * c_STRIDE;
                    w_awvalid_nxt = 1'b1;
                end
            end
            AW: begin
                if (axi_awready) begin
                    w_state_nxt   = W;
                    w_awvalid_nxt = 1'b0;
                    w_beat_nxt    = '0;
                    w_wdata_nxt   = w_beats[0];
                    w_wstrb_nxt   = w_strbs[0];
                    w_wlast_nxt   = (c_BEATS == 1);
                    w_wvalid_nxt  = 1'b1;
                end
            end
            W: begin
                if (axi_wready) begin
                    if (r_wlast) begin
                        // head is released only once its last beat is taken
                        w_state_nxt  = B;
                        w_wvalid_nxt = 1'b0;
                        w_bready_nxt = 1'b1;
                        w_pop        = 1'b1;
                    end else begin
                        w_beat_nxt  = w_beat_inc;
                        w_wdata_nxt = w_beats[w_beat_inc];
                        w_wstrb_nxt = w_strbs[w_beat_inc];
                        w_wlast_nxt = (w_beat_inc == c_LAST_BEAT);
                    end
                end
            end
            B: begin
                if (axi_bvalid) begin
                    w_state_nxt  = IDLE;
                    w_bready_nxt = 1'b0;
                    w_resp_evt   = 1'b1;
                    w_err_set    = (axi_bresp != AXI_RESP_OKAY);
                    w_batch_done = (r_resp_cnt == c_LAST_RESP);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_beat    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_wlast   <= w_wlast_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_beat    <= w_beat_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_running     <= 1'b0;
            r_all_done    <= 1'b0;
            r_write_error <= 1'b0;
            r_overflow    <= 1'b0;
            r_push_cnt    <= '0;
            r_resp_cnt    <= '0;
            r_wr_idx      <= '0;
        end else if (w_start) begin
            r_running     <= 1'b1;
            r_all_done    <= 1'b0;
            r_write_error <= 1'b0;
            r_overflow    <= 1'b0;
            r_push_cnt    <= '0;
            r_resp_cnt    <= '0;
            r_wr_idx      <= '0;
        end else begin
            if (w_push)    r_push_cnt <= r_push_cnt + c_CNT_W'(1);
            if (w_ovf_set) r_overflow <= 1'b1;
            if (w_resp_evt) begin
                r_resp_cnt <= r_resp_cnt + c_CNT_W'(1);
                r_wr_idx   <= r_wr_idx + 32'd1;
            end
            if (w_err_set) r_write_error <= 1'b1;
            if (w_batch_done) begin
                r_all_done <= 1'b1;
                r_running  <= 1'b0;
            end
        end
    end

    assign axi_awaddr      = r_awaddr;
    assign axi_awlen       = 8'(c_BEATS - 1);
    assign axi_awsize      = AXI_SIZE_64B;
    assign axi_awburst     = AXI_BURST_INCR;
    assign axi_awvalid     = r_awvalid;
    assign axi_wdata       = r_wdata;
    assign axi_wstrb       = r_wstrb;
    assign axi_wlast       = r_wlast;
    assign axi_wvalid      = r_wvalid;
    assign axi_bready      = r_bready;
    assign all_X_k_written = r_all_done;
    assign write_error     = r_write_error;
    assign overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_writer_xk.sv
`default_nettype none
// ============================================================================
// tb_ddr4_writer_xk -- directed-vector bench for ddr4_writer_xk
// Rev 1.0
// ============================================================================
module tb_ddr4_writer_xk;

    localparam int SD = 12;
    localparam int VW = SD * 64;

    logic          clk = 1'b0;
    logic          rst, start_write, start8, X_k_valid_in, valid8;
    logic [VW-1:0] X_k_in;
    logic          axi_awready, axi_wready, axi_bvalid;
    logic [1:0]    axi_bresp;

    logic          X_k_ready, axi_awvalid, axi_wlast, axi_wvalid, axi_bready;
    logic          all_X_k_written, write_error, overflow;
    logic [31:0]   axi_awaddr;
    logic [7:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic [1:0]    axi_awburst;
    logic [511:0]  axi_wdata;
    logic [63:0]   axi_wstrb;

    logic          d8_ready, d8_awvalid, d8_wlast, d8_wvalid, d8_bready;
    logic          d8_all, d8_err, d8_ovf;
    logic [31:0]   d8_awaddr;
    logic [7:0]    d8_awlen;
    logic [2:0]    d8_awsize;
    logic [1:0]    d8_awburst;
    logic [511:0]  d8_wdata;
    logic [63:0]   d8_wstrb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr4_writer_xk #(.STATE_DIM(SD), .MAX_ITERATIONS(3), .ADDR_XK_BASE(32'h0080_0000), .WB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start_write(start_write), .X_k_in(X_k_in),
        .X_k_valid_in(X_k_valid_in), .X_k_ready(X_k_ready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .all_X_k_written(all_X_k_written), .write_error(write_error), .overflow(overflow)
    );

    ddr4_writer_xk #(.STATE_DIM(SD), .MAX_ITERATIONS(8), .ADDR_XK_BASE(32'h0080_0000), .WB_DEPTH(4)) dut8 (
        .clk(clk), .rst(rst), .start_write(start8), .X_k_in(X_k_in),
        .X_k_valid_in(valid8), .X_k_ready(d8_ready),
        .axi_awaddr(d8_awaddr), .axi_awlen(d8_awlen), .axi_awsize(d8_awsize),
        .axi_awburst(d8_awburst), .axi_awvalid(d8_awvalid), .axi_awready(axi_awready),
        .axi_wdata(d8_wdata), .axi_wstrb(d8_wstrb), .axi_wlast(d8_wlast),
        .axi_wvalid(d8_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(d8_bready),
        .all_X_k_written(d8_all), .write_error(d8_err), .overflow(d8_ovf)
    );

    function automatic logic [VW-1:0] mk_vec(input int base);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < SD; i++) v[i*64 +: 64] = 64'(base + i);
        return v;
    endfunction

    function automatic logic [511:0] mk_beat(input int base, input int b);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            if (b * 8 + j < SD) r[j*64 +: 64] = 64'(base + b * 8 + j);
        return r;
    endfunction

    task automatic do_reset();
        start_write = 1'b0; start8 = 1'b0; X_k_valid_in = 1'b0; valid8 = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start();
        start_write = 1'b1;
        @(negedge clk);
        start_write = 1'b0;
    endtask

    task automatic push(input logic [VW-1:0] v);
        X_k_in = v;
        X_k_valid_in = 1'b1;
        @(negedge clk);
        X_k_valid_in = 1'b0;
    endtask

    // Acts as the AXI slave for one whole transaction on dut; no checking here.
    task automatic serve_one(input logic [1:0] resp, output logic [31:0] addr,
                             output logic [63:0] lane0, output bit ok);
        int n;
        ok = 1'b0; addr = '0; lane0 = '0;
        axi_awready = 1'b1; axi_wready = 1'b1;
        n = 0;
        while (!axi_awvalid && n < 20) begin @(negedge clk); n++; end
        if (axi_awvalid) begin
            addr = axi_awaddr;
            @(negedge clk);
            axi_awready = 1'b0;
            lane0 = axi_wdata[63:0];
            n = 0;
            while (!(axi_wvalid && axi_wlast) && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
            axi_wready = 1'b0;
            if (axi_bready) begin
                axi_bresp = resp; axi_bvalid = 1'b1;
                @(negedge clk);
                axi_bvalid = 1'b0; axi_bresp = 2'b00;
                ok = 1'b1;
            end
        end
        axi_awready = 1'b0; axi_wready = 1'b0;
    endtask

    task automatic test_reset();
        start_write = 1'b0; start8 = 1'b0; X_k_valid_in = 1'b0; valid8 = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        X_k_in = '0; rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({axi_awvalid, axi_wvalid, axi_bready, X_k_ready} !== 4'b0000) begin
            n_err++; $display("FAIL reset_valids: got %b required 0000", {axi_awvalid, axi_wvalid, axi_bready, X_k_ready});
        end
        n_vec++;
        if ({all_X_k_written, write_error, overflow} !== 3'b000) begin
            n_err++; $display("FAIL reset_status: got %b required 000", {all_X_k_written, write_error, overflow});
        end
        n_vec++;
        if (axi_awaddr !== 32'h0 || axi_wdata !== '0 || axi_wstrb !== 64'h0 || axi_wlast !== 1'b0) begin
            n_err++; $display("FAIL reset_regs: awaddr %h wstrb %h wlast %b required zeros", axi_awaddr, axi_wstrb, axi_wlast);
        end
        n_vec++;
        if ({axi_awlen, axi_awsize, axi_awburst} !== {8'd1, 3'b110, 2'b01}) begin
            n_err++; $display("FAIL const_aw: len %0d size %b burst %b required 1 110 01", axi_awlen, axi_awsize, axi_awburst);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        do_start();
        axi_awready = 1'b1; axi_wready = 1'b1;
        n_vec++;
        if (X_k_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b required 1", X_k_ready); end
        push(mk_vec(1));
        n_vec++;
        if (axi_awvalid !== 1'b0) begin n_err++; $display("FAIL lat_cycle1: awvalid %b required 0", axi_awvalid); end
        @(negedge clk);
        n_vec++;
        if (axi_awvalid !== 1'b1 || axi_awaddr !== 32'h0080_0000 || axi_awlen !== 8'd1) begin
            n_err++; $display("FAIL single_aw: awvalid %b awaddr %h awlen %0d required 1 00800000 1", axi_awvalid, axi_awaddr, axi_awlen);
        end
        @(negedge clk);
        n_vec++;
        if (axi_wvalid !== 1'b1 || axi_wdata !== mk_beat(1, 0) || axi_wstrb !== {64{1'b1}} || axi_wlast !== 1'b0 || axi_awvalid !== 1'b0) begin
            n_err++; $display("FAIL beat0: wvalid %b wstrb %h wlast %b wdata %h required wdata %h", axi_wvalid, axi_wstrb, axi_wlast, axi_wdata, mk_beat(1, 0));
        end
        @(negedge clk);
        n_vec++;
        if (axi_wvalid !== 1'b1 || axi_wdata !== mk_beat(1, 1) || axi_wstrb !== 64'h0000_0000_FFFF_FFFF || axi_wlast !== 1'b1) begin
            n_err++; $display("FAIL beat1: wvalid %b wstrb %h wlast %b wdata %h required wdata %h", axi_wvalid, axi_wstrb, axi_wlast, axi_wdata, mk_beat(1, 1));
        end
        @(negedge clk);
        n_vec++;
        if (axi_wvalid !== 1'b0 || axi_bready !== 1'b1) begin
            n_err++; $display("FAIL single_b: wvalid %b bready %b required 0 1", axi_wvalid, axi_bready);
        end
        axi_bvalid = 1'b1;
        @(negedge clk);
        axi_bvalid = 1'b0;
        n_vec++;
        if (axi_bready !== 1'b0 || all_X_k_written !== 1'b0) begin
            n_err++; $display("FAIL single_done: bready %b all_written %b required 0 0", axi_bready, all_X_k_written);
        end
        axi_awready = 1'b0; axi_wready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        logic [63:0] lane0;
        bit          ok;
        do_reset();
        do_start();
        X_k_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            X_k_in = mk_vec(100 + 16 * k);
            @(negedge clk);
        end
        X_k_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            serve_one(2'b00, addr, lane0, ok);
            n_vec++;
            if (ok !== 1'b1 || addr !== 32'h0080_0000 + 32'(k * 128) || lane0 !== 64'(100 + 16 * k)) begin
                n_err++; $display("FAIL b2b_txn%0d: ok %b addr %h lane0 %0d required addr %h lane0 %0d",
                                  k, ok, addr, lane0, 32'h0080_0000 + 32'(k * 128), 100 + 16 * k);
            end
            n_vec++;
            if (all_X_k_written !== (k == 2)) begin
                n_err++; $display("FAIL b2b_all%0d: got %b required %b", k, all_X_k_written, (k == 2));
            end
        end
        n_vec++;
        if (X_k_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after: got %b required 0", X_k_ready); end
        push(mk_vec(900));
        repeat (3) @(negedge clk);
        n_vec++;
        if (overflow !== 1'b0 || axi_awvalid !== 1'b0 || all_X_k_written !== 1'b1) begin
            n_err++; $display("FAIL b2b_drop: overflow %b awvalid %b all %b required 0 0 1", overflow, axi_awvalid, all_X_k_written);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]  addr0;
        logic [511:0] pd;
        logic [63:0]  ps;
        logic         pl;
        bit           hold;
        int           n, beats;
        do_reset();
        do_start();
        push(mk_vec(200));
        n = 0;
        while (!axi_awvalid && n < 10) begin @(negedge clk); n++; end
        n_vec++;
        if (axi_awvalid !== 1'b1) begin n_err++; $display("FAIL bp_aw_timeout: awvalid %b required 1", axi_awvalid); end
        addr0 = axi_awaddr;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (axi_awvalid !== 1'b1 || axi_awaddr !== addr0 || axi_wvalid !== 1'b0) begin
                n_err++; $display("FAIL bp_aw_hold%0d: awvalid %b awaddr %h required 1 %h", c, axi_awvalid, axi_awaddr, addr0);
            end
        end
        axi_awready = 1'b1;
        @(negedge clk);
        axi_awready = 1'b0;
        hold = 1'b0; beats = 0; pd = '0; ps = '0; pl = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (axi_wvalid) begin
                if (hold) begin
                    n_vec++;
                    if (axi_wdata !== pd || axi_wstrb !== ps || axi_wlast !== pl) begin
                        n_err++; $display("FAIL bp_w_stable%0d: wstrb %h wlast %b required %h %b", c, axi_wstrb, axi_wlast, ps, pl);
                    end
                end
                pd = axi_wdata; ps = axi_wstrb; pl = axi_wlast;
            end
            axi_wready = (c % 2 == 1);
            if (axi_wvalid && axi_wready) begin
                n_vec++;
                if (axi_wdata !== mk_beat(200, beats) || axi_wlast !== (beats == 1)) begin
                    n_err++; $display("FAIL bp_beat%0d: wlast %b wdata %h required %h", beats, axi_wlast, axi_wdata, mk_beat(200, beats));
                end
                beats++;
            end
            hold = axi_wvalid && !axi_wready;
            @(negedge clk);
        end
        axi_wready = 1'b0;
        n_vec++;
        if (beats != 2 || axi_bready !== 1'b1) begin
            n_err++; $display("FAIL bp_beat_count: beats %0d bready %b required 2 1", beats, axi_bready);
        end
        axi_bvalid = 1'b1;
        @(negedge clk);
        axi_bvalid = 1'b0;
    endtask

    task automatic test_write_error();
        logic [31:0] addr;
        logic [63:0] lane0;
        bit          ok;
        do_reset();
        do_start();
        for (int k = 0; k < 3; k++) push(mk_vec(10 * k));
        for (int k = 0; k < 3; k++) begin
            serve_one((k == 1) ? 2'b10 : 2'b00, addr, lane0, ok);
            n_vec++;
            if (ok !== 1'b1 || write_error !== (k >= 1) || all_X_k_written !== (k == 2)) begin
                n_err++; $display("FAIL werr_txn%0d: ok %b write_error %b all %b required 1 %b %b",
                                  k, ok, write_error, all_X_k_written, (k >= 1), (k == 2));
            end
        end
        do_start();
        n_vec++;
        if (write_error !== 1'b0 || all_X_k_written !== 1'b0 || X_k_ready !== 1'b1) begin
            n_err++; $display("FAIL werr_restart: write_error %b all %b ready %b required 0 0 1", write_error, all_X_k_written, X_k_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] addr;
        logic [63:0] lane0;
        bit          ok;
        int          n;
        do_reset();
        do_start();
        axi_awready = 1'b1;
        push(mk_vec(300));
        n = 0;
        while (!axi_wvalid && n < 10) begin @(negedge clk); n++; end
        axi_awready = 1'b0;
        n_vec++;
        if (axi_wvalid !== 1'b1) begin n_err++; $display("FAIL rmid_w_timeout: wvalid %b required 1", axi_wvalid); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({axi_wvalid, axi_awvalid, axi_bready, X_k_ready, all_X_k_written} !== 5'b00000) begin
            n_err++; $display("FAIL rmid_async: got %b required 00000", {axi_wvalid, axi_awvalid, axi_bready, X_k_ready, all_X_k_written});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        push(mk_vec(400));
        serve_one(2'b00, addr, lane0, ok);
        n_vec++;
        if (ok !== 1'b1 || addr !== 32'h0080_0000 || lane0 !== 64'd400) begin
            n_err++; $display("FAIL rmid_rewrite: ok %b addr %h lane0 %0d required 1 00800000 400", ok, addr, lane0);
        end
    endtask

    task automatic test_overflow();
        int got;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (d8_ready !== (k < 4)) begin
                n_err++; $display("FAIL ovf_ready%0d: got %b required %b", k, d8_ready, (k < 4));
            end
            X_k_in = mk_vec(500 + 16 * k);
            valid8 = 1'b1;
            @(negedge clk);
        end
        valid8 = 1'b0;
        n_vec++;
        if (d8_ovf !== 1'b1 || d8_ready !== 1'b0) begin
            n_err++; $display("FAIL ovf_flag: overflow %b ready %b required 1 0", d8_ovf, d8_ready);
        end
        axi_awready = 1'b1; axi_wready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            axi_bvalid = d8_bready;
            if (d8_wvalid && !d8_wlast) begin
                n_vec++;
                if (d8_wdata[63:0] !== 64'(500 + 16 * got)) begin
                    n_err++; $display("FAIL ovf_drain%0d: lane0 %0d required %0d", got, d8_wdata[63:0], 500 + 16 * got);
                end
                got++;
            end
            @(negedge clk);
        end
        axi_bvalid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
        n_vec++;
        if (got != 4 || d8_ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_count: vectors %0d overflow %b required 4 1", got, d8_ovf);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_write_error();
        test_reset_mid();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr4_writer_xk.md
Name: ddr4_writer_xk

Overview:
- Drains Kalman state estimates X_k (STATE_DIM x 64-bit) from the filter core into DDR4 over a 512-bit AXI4 write channel.
- Write-side counterpart of the Z_k measurement reader: one X_k vector is one INCR burst at a fixed 64B-aligned stride from ADDR_XK_BASE.
- A small vector FIFO decouples the core's single-cycle result pulses from AXI backpressure.

Parameters:
- STATE_DIM, 12, number of 64-bit elements per X_k vector (1..64).
- MAX_ITERATIONS, 100, vectors written per batch.
- ADDR_XK_BASE, 32'h0080_0000, DDR byte address of vector 0.
- WB_DEPTH, 4, write-buffer depth in whole vectors (power of 2, >=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_write  in  1  starts a batch; sampled only when idle or done.
- X_k_in  in  64 x [STATE_DIM]  state vector.
- X_k_valid_in  in  1  push strobe; accepted when X_k_ready=1.
- X_k_ready  out  1  = running & !done_accepting & !fifo_full.
- axi_awaddr  out  32; axi_awlen out 8; axi_awsize out 3; axi_awburst out 2; axi_awvalid out 1; axi_awready in 1.
- axi_wdata  out  512; axi_wstrb out 64; axi_wlast out 1; axi_wvalid out 1; axi_wready in 1.
- axi_bresp  in  2; axi_bvalid in 1; axi_bready out 1.
- all_X_k_written  out  1  level; high after the MAX_ITERATIONS-th B response, held until next start_write.
- write_error  out  1  sticky; any bresp != OKAY in the batch.
- overflow  out  1  sticky; a push arrived while the FIFO was full.

Behaviour:
- Constants: BEATS = ceil(STATE_DIM*8/64); STRIDE = BEATS*64; awlen = BEATS-1; awsize = 3'b110; awburst = INCR. The last three are constant outputs.
- Reset (async): every registered output is 0, FSM goes to IDLE, FIFO is emptied, all counters clear, running=0. X_k_ready=0. Reset mid-burst abandons the transaction with no completion.
- Start: when !running or all_X_k_written, start_write=1 sets running=1 and clears all_X_k_written, write_error, overflow, push_cnt, wr_idx, resp_cnt and the FIFO. start_write during an active batch is ignored.
- Push: X_k_valid_in & X_k_ready writes the vector to the FIFO and increments push_cnt.
  - done_accepting = (push_cnt == MAX_ITERATIONS). Pushes after that are silently dropped.
  - A push while running, fifo_full and !done_accepting sets overflow and drops the vector.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- FSM IDLE -> AW: when FIFO is non-empty, register axi_awaddr = ADDR_XK_BASE + wr_idx*STRIDE (mod 2^32) and raise awvalid.
  - Latency: a push accepted into an empty FIFO with the FSM in IDLE gives awvalid high 2 cycles later.
- AW: hold awvalid and awaddr stable until awready. On handshake: awvalid=0, beat=0, present beat 0 with wvalid=1, go to W.
- W: hold wdata, wstrb, wlast and wvalid stable until wready.
  - Beat b, lane j (bits j*64+:64) = element b*8+j if that element is < STATE_DIM, else 0.
  - wstrb byte k = 1 iff byte b*64+k < STATE_DIM*8. Example: STATE_DIM=12, beat 1 gives 64'h0000_0000_FFFF_FFFF.
  - wlast = (b == BEATS-1).
  - After the wlast handshake: wvalid=0, bready=1, pop the FIFO head, go to B.
- B: bready held high. On bvalid: bready=0, resp_cnt+1, wr_idx+1; if bresp != 2'b00 set write_error.
  - If resp_cnt+1 == MAX_ITERATIONS: set all_X_k_written, clear running, go to IDLE.
  - Otherwise go to IDLE.
- Exactly one outstanding transaction. AW always precedes W. The FIFO head stays occupied until its W phase completes.

Decomposition:
- Package ddr4_wr_pkg:
  - FSM enum {IDLE, AW, W, B} (2-bit).
  - AXI constants AXI_SIZE_64B=3'b110, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
  - Function beats_for(dim).
- Sub-module vec_fifo:
  - Synchronous FIFO, WB_DEPTH x (STATE_DIM*64) bits.
  - Ports: push, pop, full, empty, head.
  - Wrap via pointer mod WB_DEPTH, with an explicit count.

Test Plan (STATE_DIM=12, MAX_ITERATIONS=3, base 0x0080_0000, STRIDE=128, awlen=1):
- Single vector, elements 1..12, ready always high. Expect:
  - awaddr=0x0080_0000, awlen=1.
  - Beat 0: lanes 1..8, wstrb all ones, wlast=0.
  - Beat 1: lanes 9..12 with upper lanes 0, wstrb=64'h0000_0000_FFFF_FFFF, wlast=1.
  - Push-to-awvalid latency of 2 cycles.
- Three pushes back-to-back → AW addresses 0x0080_0000, 0x0080_0080, 0x0080_0100. all_X_k_written rises the cycle after the 3rd bvalid. A 4th push is dropped with overflow=0.
- awready held low 10 cycles, wready toggled every other cycle → awaddr, wdata, wstrb and wlast stable while valid and !ready; no beat lost or duplicated.
- WB_DEPTH=4, awready=0, 5 pushes with MAX_ITERATIONS=8 → X_k_ready falls after the 4th, overflow=1, FIFO holds the first 4.
- 2nd bresp=2'b10 → write_error=1 and stays set; batch still completes; next start_write clears it.
- rst pulsed mid-W of beat 0 → wvalid, awvalid, bready, X_k_ready and all_X_k_written are 0 immediately. A fresh start_write rewrites from 0x0080_0000.
